// File: rtl/vcm_i2c_pkg.sv
// Shared definitions for the VCM focus-driver I2C responder.
// Holds the responder state enum, the default device address, the number of
// data bytes that make up one focus word, the bit span of the focus position
// inside that word, and a small helper that picks a read-back byte.
package vcm_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic [6:0] VCM_ADDR7    = 7'h0C;
  localparam int         VCM_WR_BYTES = 2;
  localparam int         VCM_POS_MSB  = 13;
  localparam int         VCM_POS_LSB  = 4;

  // Byte 0 of the focus word is the high byte, byte 1 the low byte.
  function automatic logic [7:0] vcmByte(input logic [15:0] word, input logic idx);
    return idx ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/vcm_i2c_slave_if.sv
// I2C bus bundle between a master (or the pad ring) and the VCM responder.
//   scl   : bus clock level as seen on the wire
//   sda   : resolved (wired-AND) data level as seen on the wire
//   sdaOe : responder pulls SDA low while high; the pad's open-drain buffer
//           turns this into 0 / 'z', so the responder never drives a 1
interface vcm_i2c_slave_if;

  logic scl;
  logic sda;
  logic sdaOe;

  modport slave  (input scl, input sda, output sdaOe);
  modport master (output scl, output sda, input sdaOe);

endinterface

// File: rtl/i2c_line_filter.sv
// Conditions one asynchronous I2C line for use in the clk domain.
// A 2-flop synchronizer is followed by a glitch filter that only accepts a
// new level after FILTER_LEN consecutive equal samples, then one-cycle
// rise/fall strobes are produced in the same cycle the filtered level moves.
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_pad        : raw line level
//   o_level      : filtered level (resets to the idle-high bus level)
//   o_rise/o_fall: one-cycle strobes on filtered transitions
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [2:0] LAST_CNT = 3'(FILTER_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;
  logic [2:0] r_cnt;

  // Synchronize, then count how long the synchronized sample has disagreed
  // with the accepted level; any agreeing sample restarts the count, so a
  // pulse shorter than FILTER_LEN cycles never reaches r_level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/vcm_i2c_slave.sv
// I2C responder standing in for the camera VCM focus driver.
// Accepts a two-byte focus word written to SLAVE_ADDR7, commits it at STOP or
// repeated START, and returns the committed word on read-back.
// Ports:
//   i_clk, i_rst : 50 MHz system clock, synchronous active-high reset
//   bus          : I2C bus (scl/sda in, sdaOe open-drain pull-down out)
//   o_vcmReg     : committed focus word {byte0, byte1}
//   o_vcmPos     : focus position field of o_vcmReg
//   o_vcmPd      : power-down bit of o_vcmReg
//   o_wrStrobe   : one-cycle pulse when o_vcmReg is updated
//   o_busy       : high from accepted address match to STOP/START
module vcm_i2c_slave
  import vcm_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR7 = VCM_ADDR7,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vcm_i2c_slave_if.slave        bus,
  output logic [15:0]           o_vcmReg,
  output logic [9:0]            o_vcmPos,
  output logic                  o_vcmPd,
  output logic                  o_wrStrobe,
  output logic                  o_busy
);

  logic w_scl, w_sclRise, w_sclFall;
  logic w_sda, w_sdaRise, w_sdaFall;
  logic w_start, w_stop;

  state_t      r_state,    w_stateNext;
  logic [7:0]  r_shift,    w_shiftNext;
  logic [3:0]  r_bitCnt,   w_bitCntNext;
  logic [1:0]  r_byteCnt,  w_byteCntNext;
  logic [15:0] r_shadow,   w_shadowNext;
  logic        r_rdIdx,    w_rdIdxNext;
  logic        r_sdaOe,    w_sdaOeNext;
  logic        r_busy,     w_busyNext;
  logic [15:0] r_vcmReg,   w_vcmRegNext;
  logic        r_wrStrobe, w_wrStrobeNext;

  logic [7:0]  w_firstByte;
  logic [7:0]  w_nextByte;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sclFilter (
    .i_clk(i_clk), .i_rst(i_rst), .i_pad(bus.scl),
    .o_level(w_scl), .o_rise(w_sclRise), .o_fall(w_sclFall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sdaFilter (
    .i_clk(i_clk), .i_rst(i_rst), .i_pad(bus.sda),
    .o_level(w_sda), .o_rise(w_sdaRise), .o_fall(w_sdaFall)
  );

  assign w_start     = w_sdaFall & w_scl;
  assign w_stop      = w_sdaRise & w_scl;
  assign w_firstByte = vcmByte(r_vcmReg, 1'b0);
  assign w_nextByte  = vcmByte(r_vcmReg, ~r_rdIdx);

  // State and datapath registers; reset releases SDA and drops any
  // half-received word without committing it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_byteCnt  <= '0;
      r_shadow   <= '0;
      r_rdIdx    <= 1'b0;
      r_sdaOe    <= 1'b0;
      r_busy     <= 1'b0;
      r_vcmReg   <= '0;
      r_wrStrobe <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shift    <= w_shiftNext;
      r_bitCnt   <= w_bitCntNext;
      r_byteCnt  <= w_byteCntNext;
      r_shadow   <= w_shadowNext;
      r_rdIdx    <= w_rdIdxNext;
      r_sdaOe    <= w_sdaOeNext;
      r_busy     <= w_busyNext;
      r_vcmReg   <= w_vcmRegNext;
      r_wrStrobe <= w_wrStrobeNext;
    end
  end

  // Bus protocol. START/STOP override every bit event and close out the
  // current transfer, committing the shadow only when exactly two bytes were
  // ACKed. Data bits are sampled on SCL rise; everything the responder puts
  // on SDA changes on SCL fall so it is stable for the whole high phase.
  always_comb begin
    w_stateNext    = r_state;
    w_shiftNext    = r_shift;
    w_bitCntNext   = r_bitCnt;
    w_byteCntNext  = r_byteCnt;
    w_shadowNext   = r_shadow;
    w_rdIdxNext    = r_rdIdx;
    w_sdaOeNext    = r_sdaOe;
    w_busyNext     = r_busy;
    w_vcmRegNext   = r_vcmReg;
    w_wrStrobeNext = 1'b0;

    if (w_start || w_stop) begin
      if (r_byteCnt == 2'(VCM_WR_BYTES)) begin
        w_vcmRegNext   = r_shadow;
        w_wrStrobeNext = 1'b1;
      end
      w_stateNext   = w_start ? ST_ADDR : ST_IDLE;
      w_bitCntNext  = '0;
      w_byteCntNext = '0;
      w_shadowNext  = '0;
      w_sdaOeNext   = 1'b0;
      w_busyNext    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
        end
        ST_ADDR: begin
          if (w_sclRise) begin
            w_shiftNext  = {r_shift[6:0], w_sda};
            w_bitCntNext = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            if (r_shift[7:1] == SLAVE_ADDR7) begin
              w_stateNext = ST_ADDR_ACK;
              w_sdaOeNext = 1'b1;
              w_busyNext  = 1'b1;
            end else begin
              w_stateNext = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          // r_shift still holds the address byte, so bit 0 is R/W.
          if (w_sclFall) begin
            w_bitCntNext = '0;
            if (r_shift[0]) begin
              w_stateNext = ST_RD_BYTE;
              w_rdIdxNext = 1'b0;
              w_shiftNext = w_firstByte;
              w_sdaOeNext = ~w_firstByte[7];
            end else begin
              w_stateNext = ST_WR_BYTE;
              w_sdaOeNext = 1'b0;
            end
          end
        end
        ST_WR_BYTE: begin
          if (w_sclRise) begin
            w_shiftNext  = {r_shift[6:0], w_sda};
            w_bitCntNext = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            if (r_byteCnt < 2'(VCM_WR_BYTES)) begin
              if (r_byteCnt == 2'd0) w_shadowNext[15:8] = r_shift;
              else                   w_shadowNext[7:0]  = r_shift;
              w_byteCntNext = r_byteCnt + 2'd1;
              w_sdaOeNext   = 1'b1;
              w_stateNext   = ST_WR_ACK;
            end else begin
              w_stateNext = ST_WAIT_STOP;
            end
          end
        end
        ST_WR_ACK: begin
          if (w_sclFall) begin
            w_sdaOeNext  = 1'b0;
            w_bitCntNext = '0;
            w_stateNext  = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          // r_bitCnt counts bits already completed; the MSB of r_shift is on
          // the wire, and a '1' is presented by releasing the line.
          if (w_sclFall) begin
            if (r_bitCnt == 4'd7) begin
              w_sdaOeNext = 1'b0;
              w_stateNext = ST_RD_ACK;
            end else begin
              w_bitCntNext = r_bitCnt + 4'd1;
              w_shiftNext  = {r_shift[6:0], 1'b0};
              w_sdaOeNext  = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          // A fall here can only follow an ACKed rise; a NACK leaves first.
          if (w_sclRise && w_sda) begin
            w_stateNext = ST_WAIT_STOP;
          end else if (w_sclFall) begin
            w_rdIdxNext  = ~r_rdIdx;
            w_shiftNext  = w_nextByte;
            w_sdaOeNext  = ~w_nextByte[7];
            w_bitCntNext = '0;
            w_stateNext  = ST_RD_BYTE;
          end
        end
        ST_WAIT_STOP: begin
          w_sdaOeNext = 1'b0;
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_sdaOeNext = 1'b0;
        end
      endcase
    end
  end

  assign bus.sdaOe  = r_sdaOe;
  assign o_vcmReg   = r_vcmReg;
  assign o_vcmPos   = r_vcmReg[VCM_POS_MSB:VCM_POS_LSB];
  assign o_vcmPd    = r_vcmReg[15];
  assign o_wrStrobe = r_wrStrobe;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_vcm_i2c_slave.sv
// Directed bench for vcm_i2c_slave: a bit-banged 400 kHz I2C master drives
// the bus interface, SDA is resolved as a wired-AND of master and responder,
// and each scenario task checks its own hand-computed results.
module tb_vcm_i2c_slave;

  localparam int Q = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        masterScl = 1'b1;
  logic        masterSda = 1'b1;
  logic [15:0] vcmReg;
  logic [9:0]  vcmPos;
  logic        vcmPd;
  logic        wrStrobe;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;
  int strobeCount = 0;
  int oeCycles = 0;
  int busyCycles = 0;

  vcm_i2c_slave_if bus ();

  assign bus.scl = masterScl;
  assign bus.sda = masterSda & ~bus.sdaOe;

  vcm_i2c_slave #(.SLAVE_ADDR7(7'h0C), .FILTER_LEN(3)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_vcmReg(vcmReg),
    .o_vcmPos(vcmPos),
    .o_vcmPd(vcmPd),
    .o_wrStrobe(wrStrobe),
    .o_busy(busy)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Activity counters so scenarios can check "never happened" conditions.
  always @(posedge clk) begin
    if (wrStrobe) strobeCount++;
    if (bus.sdaOe) oeCycles++;
    if (busy) busyCycles++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    masterSda = 1'b1; masterScl = 1'b1; waitCycles(Q);
    masterSda = 1'b0; waitCycles(Q);
    masterScl = 1'b0; waitCycles(Q);
  endtask

  task automatic i2cRepStart();
    masterSda = 1'b1; waitCycles(Q);
    masterScl = 1'b1; waitCycles(Q);
    masterSda = 1'b0; waitCycles(Q);
    masterScl = 1'b0; waitCycles(Q);
  endtask

  task automatic i2cStop();
    masterSda = 1'b0; waitCycles(Q);
    masterScl = 1'b1; waitCycles(Q);
    masterSda = 1'b1; waitCycles(Q);
  endtask

  task automatic writeBit(input logic b, input logic glitch);
    masterSda = b;
    if (glitch) begin
      waitCycles(10);
      masterScl = 1'b1; waitCycles(2);
      masterScl = 1'b0; waitCycles(Q - 12);
    end else begin
      waitCycles(Q);
    end
    masterScl = 1'b1; waitCycles(2 * Q);
    masterScl = 1'b0; waitCycles(Q);
  endtask

  task automatic readBit(output logic b);
    masterSda = 1'b1; waitCycles(Q);
    masterScl = 1'b1; waitCycles(Q);
    b = bus.sda;      waitCycles(Q);
    masterScl = 1'b0; waitCycles(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, input int glitchBit, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i], i == glitchBit);
    readBit(ack);
  endtask

  task automatic readByte(input logic ackBit, output logic [7:0] d);
    logic [7:0] v;
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      readBit(bt);
      v[i] = bt;
    end
    writeBit(ackBit, 1'b0);
    d = v;
  endtask

  task automatic applyStimulusReset();
    @(negedge clk) rst = 1'b1;
    waitCycles(4);
    rst = 1'b0;
    waitCycles(4);
  endtask

  task automatic test_reset();
    applyStimulusReset();
    testsRun++; if (vcmReg !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_reg: got %h want 0000", vcmReg); end
    testsRun++; if (vcmPos !== 10'h000) begin testsFailed++; $display("[TB] FAIL reset_pos: got %h want 000", vcmPos); end
    testsRun++; if (vcmPd !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pd: got %b want 0", vcmPd); end
    testsRun++; if (wrStrobe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_strobe: got %b want 0", wrStrobe); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testsRun++; if (bus.sdaOe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sda: got %b want 0", bus.sdaOe); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int s0;
    s0 = strobeCount;
    i2cStart();
    writeByte(8'h18, -1, a0);
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL write_busy_hi: got %b want 1", busy); end
    writeByte(8'h3F, -1, a1);
    writeByte(8'hA0, -1, a2);
    i2cStop();
    testsRun++; if ({a0, a1, a2} !== 3'b000) begin testsFailed++; $display("[TB] FAIL write_acks: got %b want 000", {a0, a1, a2}); end
    testsRun++; if (vcmReg !== 16'h3FA0) begin testsFailed++; $display("[TB] FAIL write_reg: got %h want 3fa0", vcmReg); end
    testsRun++; if (vcmPos !== 10'h3FA) begin testsFailed++; $display("[TB] FAIL write_pos: got %h want 3fa", vcmPos); end
    testsRun++; if (vcmPd !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_pd: got %b want 0", vcmPd); end
    testsRun++; if (strobeCount - s0 !== 1) begin testsFailed++; $display("[TB] FAIL write_strobes: got %0d want 1", strobeCount - s0); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_busy_lo: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1;
    int s0, o0;
    s0 = strobeCount;
    i2cStart();
    writeByte(8'h19, -1, a0);
    readByte(1'b0, d0);
    readByte(1'b1, d1);
    testsRun++; if (bus.sdaOe !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_release: got %b want 0", bus.sdaOe); end
    o0 = oeCycles;
    i2cStop();
    testsRun++; if (a0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_addr_ack: got %b want 0", a0); end
    testsRun++; if (d0 !== 8'h3F) begin testsFailed++; $display("[TB] FAIL read_byte0: got %h want 3f", d0); end
    testsRun++; if (d1 !== 8'hA0) begin testsFailed++; $display("[TB] FAIL read_byte1: got %h want a0", d1); end
    testsRun++; if (oeCycles - o0 !== 0) begin testsFailed++; $display("[TB] FAIL read_after_nack: got %0d driven cycles want 0", oeCycles - o0); end
    testsRun++; if (strobeCount - s0 !== 0) begin testsFailed++; $display("[TB] FAIL read_strobes: got %0d want 0", strobeCount - s0); end
  endtask

  task automatic test_addr_nack();
    logic a0, a1, a2;
    int s0, o0, b0;
    s0 = strobeCount; o0 = oeCycles; b0 = busyCycles;
    i2cStart();
    writeByte(8'h1A, -1, a0);
    writeByte(8'h11, -1, a1);
    writeByte(8'h22, -1, a2);
    i2cStop();
    testsRun++; if ({a0, a1, a2} !== 3'b111) begin testsFailed++; $display("[TB] FAIL nack_acks: got %b want 111", {a0, a1, a2}); end
    testsRun++; if (oeCycles - o0 !== 0) begin testsFailed++; $display("[TB] FAIL nack_sda: got %0d driven cycles want 0", oeCycles - o0); end
    testsRun++; if (busyCycles - b0 !== 0) begin testsFailed++; $display("[TB] FAIL nack_busy: got %0d busy cycles want 0", busyCycles - b0); end
    testsRun++; if (vcmReg !== 16'h3FA0) begin testsFailed++; $display("[TB] FAIL nack_reg: got %h want 3fa0", vcmReg); end
    testsRun++; if (strobeCount - s0 !== 0) begin testsFailed++; $display("[TB] FAIL nack_strobes: got %0d want 0", strobeCount - s0); end
  endtask

  task automatic test_byte_count();
    logic a0, a1, a2, a3;
    int s0;
    s0 = strobeCount;
    i2cStart();
    writeByte(8'h18, -1, a0);
    writeByte(8'h12, -1, a1);
    i2cStop();
    testsRun++; if ({a0, a1} !== 2'b00) begin testsFailed++; $display("[TB] FAIL short_acks: got %b want 00", {a0, a1}); end
    testsRun++; if (vcmReg !== 16'h3FA0) begin testsFailed++; $display("[TB] FAIL short_reg: got %h want 3fa0", vcmReg); end
    testsRun++; if (strobeCount - s0 !== 0) begin testsFailed++; $display("[TB] FAIL short_strobes: got %0d want 0", strobeCount - s0); end
    i2cStart();
    writeByte(8'h18, -1, a0);
    writeByte(8'h12, -1, a1);
    writeByte(8'h34, -1, a2);
    writeByte(8'h56, -1, a3);
    i2cStop();
    testsRun++; if ({a0, a1, a2, a3} !== 4'b0001) begin testsFailed++; $display("[TB] FAIL long_acks: got %b want 0001", {a0, a1, a2, a3}); end
    testsRun++; if (vcmReg !== 16'h1234) begin testsFailed++; $display("[TB] FAIL long_reg: got %h want 1234", vcmReg); end
    testsRun++; if (vcmPos !== 10'h123) begin testsFailed++; $display("[TB] FAIL long_pos: got %h want 123", vcmPos); end
    testsRun++; if (strobeCount - s0 !== 1) begin testsFailed++; $display("[TB] FAIL long_strobes: got %0d want 1", strobeCount - s0); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;
    int s0;
    s0 = strobeCount;
    i2cStart();
    writeByte(8'h18, -1, a0);
    writeByte(8'h80, -1, a1);
    writeByte(8'h05, -1, a2);
    i2cRepStart();
    testsRun++; if (vcmReg !== 16'h8005) begin testsFailed++; $display("[TB] FAIL rs_reg: got %h want 8005", vcmReg); end
    testsRun++; if (vcmPd !== 1'b1) begin testsFailed++; $display("[TB] FAIL rs_pd: got %b want 1", vcmPd); end
    testsRun++; if (vcmPos !== 10'h000) begin testsFailed++; $display("[TB] FAIL rs_pos: got %h want 000", vcmPos); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rs_busy: got %b want 0", busy); end
    writeByte(8'h19, -1, a3);
    readByte(1'b0, d0);
    readByte(1'b1, d1);
    i2cStop();
    testsRun++; if ({a0, a1, a2, a3} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rs_acks: got %b want 0000", {a0, a1, a2, a3}); end
    testsRun++; if ({d0, d1} !== 16'h8005) begin testsFailed++; $display("[TB] FAIL rs_readback: got %h want 8005", {d0, d1}); end
    testsRun++; if (strobeCount - s0 !== 1) begin testsFailed++; $display("[TB] FAIL rs_strobes: got %0d want 1", strobeCount - s0); end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    i2cStart();
    writeByte(8'h18, -1, a0);
    writeByte(8'h5A, 4, a1);
    writeByte(8'hC3, 1, a2);
    i2cStop();
    testsRun++; if ({a0, a1, a2} !== 3'b000) begin testsFailed++; $display("[TB] FAIL glitch_acks: got %b want 000", {a0, a1, a2}); end
    testsRun++; if (vcmReg !== 16'h5AC3) begin testsFailed++; $display("[TB] FAIL glitch_reg: got %h want 5ac3", vcmReg); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    int o0;
    i2cStart();
    writeByte(8'h19, -1, a0);
    // Bit 7 of 0x5A is 0, so the responder is pulling SDA low right now.
    testsRun++; if (bus.sdaOe !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_driving: got %b want 1", bus.sdaOe); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    testsRun++; if (bus.sdaOe !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_release: got %b want 0", bus.sdaOe); end
    testsRun++; if (vcmReg !== 16'h0000) begin testsFailed++; $display("[TB] FAIL mid_reg: got %h want 0000", vcmReg); end
    @(negedge clk) rst = 1'b0;
    waitCycles(Q);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
    o0 = oeCycles;
    writeByte(8'h18, -1, a1);
    i2cStop();
    testsRun++; if (a1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_no_start_ack: got %b want 1", a1); end
    testsRun++; if (oeCycles - o0 !== 0) begin testsFailed++; $display("[TB] FAIL mid_no_start_sda: got %0d driven cycles want 0", oeCycles - o0); end
    i2cStart();
    writeByte(8'h18, -1, a1);
    writeByte(8'h0A, -1, a2);
    writeByte(8'h0B, -1, a3);
    i2cStop();
    testsRun++; if ({a1, a2, a3} !== 3'b000) begin testsFailed++; $display("[TB] FAIL mid_reacq_acks: got %b want 000", {a1, a2, a3}); end
    testsRun++; if (vcmReg !== 16'h0A0B) begin testsFailed++; $display("[TB] FAIL mid_reacq_reg: got %h want 0a0b", vcmReg); end
  endtask

  // Scenarios run back to back; each one relies on the word the previous
  // one committed.
  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_byte_count();
    test_back_to_back();
    test_glitch();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
